// File: rtl/dma_transfer_controller.sv
// Bus-master DMA engine: requests the bus, then copies XFER_LEN device words
// to memory at base..base+XFER_LEN-1, one word per mem_ack, and pulses dma_end.
module dma_transfer_controller #(
  parameter int WORD_SIZE = 16,
  parameter int XFER_LEN  = 12,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic                 BG,
  output logic                 BR,
  output logic [CNT_W-1:0]     dev_idx,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ack,
  output logic [CNT_W-1:0]     dma_counter,
  output logic                 dma_end,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, REQUEST, TRANSFER, PAUSE, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(XFER_LEN - 1);

  state_t               state_reg, state_next;
  logic [WORD_SIZE-1:0] base_reg, base_next;
  logic [CNT_W-1:0]     counter_reg, counter_next;
  logic                 busy_reg, busy_next;
  logic                 end_reg, end_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      counter_reg <= '0;
      busy_reg    <= 1'b0;
      end_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      counter_reg <= counter_next;
      busy_reg    <= busy_next;
      end_reg     <= end_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    counter_next = counter_reg;
    busy_next    = busy_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          base_next    = cmd_addr;
          counter_next = '0;
          busy_next    = 1'b1;
          state_next   = REQUEST;
        end
      end
      REQUEST: begin
        if (BG) state_next = TRANSFER;
      end
      TRANSFER: begin
        // An ack coinciding with grant loss is still honoured before pausing.
        if (mem_ack) begin
          if (counter_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            counter_next = counter_reg + 1'b1;
            if (!BG) state_next = PAUSE;
          end
        end else if (!BG) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (BG) state_next = TRANSFER;
      end
      DONE: begin
        counter_next = '0;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    end_next = (state_next == DONE);
  end

  assign BR          = (state_reg == REQUEST) || (state_reg == TRANSFER) || (state_reg == PAUSE);
  assign mem_write   = (state_reg == TRANSFER);
  assign mem_addr    = base_reg + WORD_SIZE'(counter_reg);
  assign mem_data    = dev_data;
  assign dev_idx     = counter_reg;
  assign dma_counter = counter_reg;
  assign dma_end     = end_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_dma_transfer_controller.sv
// Directed bench for dma_transfer_controller: stimulus pushes expected writes and
// completions into a scoreboard; a negedge monitor pops and compares them.
module tb_dma_transfer_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic        BG;
  logic        BR;
  logic [3:0]  dev_idx;
  logic [15:0] dev_data;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic [3:0]  dma_counter;
  logic        dma_end;
  logic        busy;

  logic        ack_en;
  logic        ack_force;
  logic [15:0] dev_pat;

  int checks = 0;
  int passed = 0;

  logic [31:0] wr_q[$];
  int          end_pending = 0;
  logic        end_prev = 1'b0;

  always #5 clk = ~clk;

  assign dev_data = dev_pat + 16'(dev_idx);
  assign mem_ack  = ack_force | (ack_en & mem_write);

  dma_transfer_controller #(.WORD_SIZE(16), .XFER_LEN(12), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .BG(BG), .BR(BR), .dev_idx(dev_idx), .dev_data(dev_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .dma_counter(dma_counter), .dma_end(dma_end), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Monitor: one line per accepted write, compared against the scoreboard.
  always @(negedge clk) begin
    if (end_prev) begin
      chk("busy_after_end", 32'(busy), 32'd0);
      end_prev = 1'b0;
    end
    if (mem_write && mem_ack) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_data}, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = wr_q.pop_front();
        $display("write addr=%h data=%h idx=%0d", mem_addr, mem_data, dma_counter);
        chk("write_addr", 32'(mem_addr), 32'(e[31:16]));
        chk("write_data", 32'(mem_data), 32'(e[15:0]));
      end
    end
    if (dma_end) begin
      $display("dma_end counter=%0d BR=%0d", dma_counter, BR);
      chk("end_expected", 32'(end_pending > 0), 32'd1);
      if (end_pending > 0) end_pending--;
      chk("end_counter", 32'(dma_counter), 32'd11);
      chk("end_br", 32'(BR), 32'd0);
      chk("end_busy", 32'(busy), 32'd1);
      end_prev = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] addr);
    cmd_addr  = addr;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) wr_q.push_back({addr + 16'(i), dev_pat + 16'(i)});
    end_pending++;
    step();
    cmd_valid = 1'b0;
    chk("cmd_to_br", 32'(BR), 32'd1);
    chk("cmd_to_busy", 32'(busy), 32'd1);
  endtask

  task automatic grant();
    repeat (2) step();
    BG = 1'b1;
    step();
    chk("bg_to_write", 32'(mem_write), 32'd1);
  endtask

  task automatic wait_counter(input logic [3:0] n);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (mem_write && dma_counter == n) hit = 1'b1;
    end
    if (!hit) chk("timeout_counter", 32'(dma_counter), 32'(n));
  endtask

  task automatic wait_end();
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (dma_end) hit = 1'b1;
      else step();
    end
    if (!hit) chk("timeout_end", 32'd0, 32'd1);
    BG = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; BG = 1'b0;
    ack_en = 1'b1; ack_force = 1'b0; dev_pat = 16'hA000;
    #1;
    chk("rst_br", 32'(BR), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_end", 32'(dma_end), 32'd0);
    chk("rst_counter", 32'(dma_counter), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Basic transfer
    start_cmd(16'h0100);
    grant();
    wait_end();

    // Grant withdrawal with acks forced during the pause
    start_cmd(16'h0400);
    grant();
    wait_counter(4'd6);
    BG = 1'b0;
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      ack_force = 1'b1;
      chk("pause_br", 32'(BR), 32'd1);
      chk("pause_write", 32'(mem_write), 32'd0);
      chk("pause_counter", 32'(dma_counter), 32'd6);
    end
    ack_force = 1'b0;
    BG = 1'b1;
    ack_en = 1'b1;
    step();
    chk("resume_addr", 32'(mem_addr), 32'h0406);
    wait_end();

    // Coincident final ack and grant loss
    start_cmd(16'h0800);
    grant();
    wait_counter(4'd11);
    BG = 1'b0;
    step();
    chk("coinc_end", 32'(dma_end), 32'd1);
    step();
    chk("coinc_no_pause", 32'(BR), 32'd0);

    // Address wrap, plus an ignored second command mid-transfer
    start_cmd(16'hFFFA);
    grant();
    wait_counter(4'd3);
    cmd_addr = 16'h0200;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_end();

    // Reset mid-transfer
    start_cmd(16'h0600);
    grant();
    wait_counter(4'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_br", 32'(BR), 32'd0);
    chk("arst_write", 32'(mem_write), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_counter", 32'(dma_counter), 32'd0);
    wr_q.delete();
    end_pending = 0;
    BG = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_end_after_reset", 32'(dma_end), 32'd0);
    end
    dev_pat = 16'hB000;
    start_cmd(16'h0300);
    grant();
    wait_end();

    repeat (2) step();
    chk("writes_drained", 32'(wr_q.size()), 32'd0);
    chk("ends_drained", 32'(end_pending), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dma_transfer_controller.md
Name: dma_transfer_controller

Overview:
- Bus-master DMA engine that moves a fixed-length block of words from an external device buffer into memory on behalf of the CPU.
- Receives a start command from the CPU, raises bus request (BR) and waits for bus grant (BG).
- Streams one word per memory acknowledge, exposing its word counter to the pipeline hazard controller, and pulses dma_end on completion.
- Sits between the CPU/memory bus, the external device and the hazard controller, which stalls the pipeline while BR is high and the D-cache misses.

Parameters:
- WORD_SIZE, 16, data and address width.
- XFER_LEN, 12, words per transfer; dma_counter runs 0..XFER_LEN-1.
- CNT_W, 4, width of dma_counter; must satisfy 2^CNT_W >= XFER_LEN.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  CPU start pulse; sampled only in IDLE.
- cmd_addr  input  WORD_SIZE  memory base address of the transfer.
- BG  input  1  bus grant from CPU; level signal.
- BR  output  1  bus request to CPU.
- dev_idx  output  CNT_W  word index presented to the device buffer.
- dev_data  input  WORD_SIZE  device word at dev_idx, combinational from the device.
- mem_write  output  1  memory write strobe, owned by DMA while granted.
- mem_addr  output  WORD_SIZE  write address (base + counter).
- mem_data  output  WORD_SIZE  write data (dev_data).
- mem_ack  input  1  memory accepted current word; 1-cycle pulse.
- dma_counter  output  CNT_W  index of the word currently being written.
- dma_end  output  1  one-cycle completion pulse to CPU.
- busy  output  1  high from command acceptance until dma_end.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE.
  - BR = 0, mem_write = 0, dma_end = 0, busy = 0.
  - dma_counter = 0, base register = 0.
  - Reset mid-transfer abandons the transfer: no dma_end and no further writes.
- States: IDLE, REQUEST, TRANSFER, PAUSE, DONE.
- IDLE:
  - cmd_valid=1 latches cmd_addr into the base register and clears the counter.
  - Next state REQUEST; busy=1 from the next cycle.
- REQUEST:
  - BR=1.
  - BG=1 → TRANSFER on the next edge.
  - Otherwise hold; no timeout.
- TRANSFER:
  - BR=1, mem_write=1.
  - mem_addr = base + dma_counter, truncated to WORD_SIZE; wrap-around past 0xFFFF is allowed.
  - dev_idx = dma_counter; mem_data = dev_data.
  - On mem_ack: if dma_counter == XFER_LEN-1 → DONE; else dma_counter += 1.
  - BG falling with no mem_ack in the same cycle → PAUSE with the counter held.
  - If mem_ack and BG falling coincide, the ack is honoured (counter increments or DONE) and then PAUSE is entered, unless the transfer finished.
- PAUSE:
  - BR=1, mem_write=0.
  - mem_ack is ignored.
  - BG=1 → TRANSFER, resuming at the held counter.
- DONE (exactly one cycle):
  - BR=0, mem_write=0, dma_end=1.
  - dma_counter holds XFER_LEN-1 during this cycle, then clears to 0 on return to IDLE.
  - busy drops on entering IDLE.
- Command handling:
  - cmd_valid outside IDLE is ignored; no queueing.
  - cmd_valid in IDLE on the same cycle DONE exits is accepted normally, since DONE→IDLE precedes it.
- All outputs are registered, except these combinational decodes of state/counter/base: mem_write, mem_addr, mem_data, dev_idx and BR.
- Latency:
  - cmd_valid to BR high: 1 cycle.
  - BG high to first mem_write: 1 cycle.
  - Minimum transfer: XFER_LEN acks, plus 3 cycles overhead.
- Invariant: dma_counter never exceeds XFER_LEN-1; the hazard controller relies on dma_counter == XFER_LEN-1 marking the final word.

Test Plan:
- Basic transfer:
  - Stimulus: cmd_addr=0x0100, cmd_valid pulse, BG raised 2 cycles after BR, mem_ack every cycle, dev_data = 0xA000 + idx.
  - Response: 12 writes to 0x0100..0x010B with data 0xA000..0xA00B; dma_end high for exactly one cycle after the ack of word 11; BR falls in the same cycle; busy drops the next cycle.
- Grant withdrawal:
  - Stimulus: BG drops after word 5 is acked, then returns 4 cycles later.
  - Response: mem_write=0 and BR=1 throughout the pause; resumes at mem_addr=base+6; 12 unique addresses total.
- Coincident events:
  - Stimulus: mem_ack and BG fall in the same cycle on word 11.
  - Response: transfer completes and dma_end pulses; no PAUSE entered.
- Address wrap:
  - Stimulus: cmd_addr=0xFFFA.
  - Response: addresses 0xFFFA..0xFFFF then 0x0000..0x0005.
- Ignored command:
  - Stimulus: second cmd_valid with cmd_addr=0x0200 during TRANSFER.
  - Response: no effect; all writes stay at the original base; exactly one dma_end.
- Reset mid-transfer:
  - Stimulus: reset_n pulsed low at word 7.
  - Response: BR, mem_write, busy and dma_counter go to 0 immediately (asynchronously); no dma_end; a new command afterwards performs a full 12-word transfer from counter 0.
